// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor fetch path:
// sequencer state encoding, the HALT encoding and the delivered-count width.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int          FETCH_CNT_W = 16;
    localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] v);
        return (v == {FETCH_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the pc, reads a combinational instruction
// memory, and hands each word to decode over a valid/ready handshake.
module instr_fetch_sequencer #(
    parameter int                  width      = 32,
    parameter int                  wordLength = 32,
    parameter logic [wordLength-1:0] HALT_WORD = {wordLength{1'b1}},
    localparam int                 AW         = (width > 1) ? $clog2(width) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [AW-1:0]         imem_addr,
    input  logic [wordLength-1:0] imem_data,
    output logic [wordLength-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [AW-1:0]         redirect_addr,
    output logic [AW-1:0]         pc,
    output logic                  halt,
    output logic [15:0]           fetch_count
);
    import proc_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(width - 1);

    fetch_state_e             state_reg, state_next;
    logic [AW-1:0]            pc_reg, pc_next;
    logic [wordLength-1:0]    instr_reg, instr_next;
    logic                     valid_reg, valid_next;
    logic                     halt_reg, halt_next;
    logic [FETCH_CNT_W-1:0]   cnt_reg, cnt_next;
    logic [AW-1:0]            pc_inc;
    logic                     handshake;

    // Explicit wrap so non-power-of-two depths return to 0 after width-1.
    assign pc_inc    = (pc_reg == LAST_ADDR) ? '0 : pc_reg + 1'b1;
    assign handshake = valid_reg & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
            valid_reg <= 1'b0;
            halt_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            halt_reg  <= halt_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        halt_next  = halt_reg;
        cnt_next   = cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next = redirect_addr;
                end else if (imem_data == HALT_WORD) begin
                    halt_next  = 1'b1;
                    state_next = HALT;
                end else begin
                    instr_next = imem_data;
                    valid_next = 1'b1;
                    pc_next    = pc_inc;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // A redirect is only honoured alongside the accepting handshake.
                if (handshake) begin
                    valid_next = 1'b0;
                    cnt_next   = sat_inc(cnt_reg);
                    state_next = FETCH;
                    if (redirect_valid) begin
                        pc_next = redirect_addr;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    pc_next    = '0;
                    halt_next  = 1'b0;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign halt        = halt_reg;
    assign fetch_count = cnt_reg;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed plus randomized checks of instr_fetch_sequencer against a
// transaction-level model of what gets delivered, when, and from where.
module tb_instr_fetch_sequencer;

    localparam int W  = 32;
    localparam int WL = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [WL-1:0] imem_data;
    logic [WL-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic [AW-1:0] pc;
    logic          halt;
    logic [15:0]   fetch_count;

    logic [WL-1:0] mem [0:W-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational-read instruction memory model.
    assign imem_data = mem[imem_addr];

    instr_fetch_sequencer #(.width(W), .wordLength(WL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .pc(pc), .halt(halt), .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Transaction-level reference state for the random phase.
    bit            m_waiting;   // an instruction is being offered
    bit            m_fetching;  // this cycle reads memory
    int            m_pc;
    int            m_src;       // address the offered instruction came from
    int            m_cnt;
    bit            rdy;
    bit            rdr;
    int            raddr;

    initial begin
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        for (int i = 0; i < W; i++) mem[i] = ($urandom & 32'h7FFF_FFF0) | 32'h100 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'hFFFF_FFFF;

        // Reset, then idle with no start.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        $display("txn reset/idle pc=%0d valid=%0b halt=%0b", pc, instr_valid, halt);
        check("idle_pc", 32'(pc), 32'd0);
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("idle_halt", 32'(halt), 32'd0);
        check("idle_count", 32'(fetch_count), 32'd0);
        check("idle_instr", instr, 32'd0);

        // Start with ready held: one delivery every two cycles.
        instr_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        check("start_fetch_valid", 32'(instr_valid), 32'd0);
        step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instr, 32'h11);
        check("first_pc", 32'(pc), 32'd1);
        step();
        check("gap_valid", 32'(instr_valid), 32'd0);
        check("count1", 32'(fetch_count), 32'd1);
        step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("second_instr", instr, 32'h22);
        check("second_valid", 32'(instr_valid), 32'd1);
        step(); step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("third_instr", instr, 32'h33);
        step();
        check("count3", 32'(fetch_count), 32'd3);
        step();
        $display("txn halt halt=%0b pc=%0d", halt, pc);
        check("halt_flag", 32'(halt), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_pc", 32'(pc), 32'd3);
        step();
        check("halt_sticky", 32'(halt), 32'd1);

        // Restart from HALT, then backpressure on the first word.
        start = 1'b1; instr_ready = 1'b0;
        step(); start = 1'b0;
        $display("txn restart halt=%0b pc=%0d count=%0d", halt, pc, fetch_count);
        check("restart_halt", 32'(halt), 32'd0);
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_count", 32'(fetch_count), 32'd3);
        step();
        check("bp_first_instr", instr, 32'h11);
        redirect_valid = 1'b1; redirect_addr = 5'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            $display("txn backpressure cycle=%0d instr=%h valid=%0b pc=%0d", i, instr, instr_valid, pc);
            check("bp_instr", instr, 32'h11);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_pc", 32'(pc), 32'd1);
        end
        redirect_valid = 1'b0; instr_ready = 1'b1;
        step();
        check("bp_count", 32'(fetch_count), 32'd4);
        step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("bp_next_instr", instr, 32'h22);
        check("bp_next_pc", 32'(pc), 32'd2);

        // Redirect on the handshake.
        redirect_valid = 1'b1; redirect_addr = 5'd5;
        step(); redirect_valid = 1'b0;
        check("hs_redir_pc", 32'(pc), 32'd5);
        check("hs_redir_count", 32'(fetch_count), 32'd5);
        step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("hs_redir_instr", instr, mem[5]);
        check("hs_redir_pc_after", 32'(pc), 32'd6);
        step();
        check("pre_fetch_redir_pc", 32'(pc), 32'd6);

        // Redirect during the fetch cycle discards the read.
        redirect_valid = 1'b1; redirect_addr = 5'd9;
        step(); redirect_valid = 1'b0;
        check("fetch_redir_valid", 32'(instr_valid), 32'd0);
        check("fetch_redir_pc", 32'(pc), 32'd9);
        step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("fetch_redir_instr", instr, mem[9]);
        check("fetch_redir_pc_after", 32'(pc), 32'd10);

        // Wrap from the last address.
        redirect_valid = 1'b1; redirect_addr = 5'd31;
        step(); redirect_valid = 1'b0;
        check("wrap_pc31", 32'(pc), 32'd31);
        step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("wrap_instr31", instr, mem[31]);
        check("wrap_pc0", 32'(pc), 32'd0);
        step(); step();
        $display("txn deliver instr=%h pc=%0d", instr, pc);
        check("wrap_instr0", instr, 32'h11);
        check("wrap_pc1", 32'(pc), 32'd1);
        check("wrap_count", 32'(fetch_count), 32'd8);

        // Asynchronous reset between edges while an instruction is held.
        instr_ready = 1'b0;
        step();
        check("pre_reset_valid", 32'(instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn async reset valid=%0b pc=%0d count=%0d", instr_valid, pc, fetch_count);
        check("areset_valid", 32'(instr_valid), 32'd0);
        check("areset_pc", 32'(pc), 32'd0);
        check("areset_count", 32'(fetch_count), 32'd0);
        check("areset_instr", instr, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Randomized phase: no HALT words, random ready and redirects.
        for (int i = 0; i < W; i++) mem[i] = ($urandom & 32'h7FFF_FFFF) ^ (i << 8);
        step();
        start = 1'b1;
        step(); start = 1'b0;
        m_waiting = 0; m_fetching = 1; m_pc = 0; m_src = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd_valid", 32'(instr_valid), 32'(m_waiting));
            check("rnd_pc", 32'(pc), 32'(m_pc));
            check("rnd_count", 32'(fetch_count), 32'(m_cnt));
            if (m_waiting) check("rnd_instr", instr, mem[m_src]);
            rdy   = ($urandom_range(0, 2) != 0);
            rdr   = ($urandom_range(0, 4) == 0);
            raddr = $urandom_range(0, W - 1);
            instr_ready    = rdy;
            redirect_valid = rdr;
            redirect_addr  = AW'(raddr);
            if (m_waiting) begin
                if (rdy) begin
                    $display("txn rnd accept instr=%h from=%0d redirect=%0b", instr, m_src, rdr);
                    m_waiting  = 0;
                    m_fetching = 1;
                    m_cnt++;
                    if (rdr) m_pc = raddr;
                end
            end else if (m_fetching) begin
                if (rdr) m_pc = raddr;
                else begin
                    m_src      = m_pc;
                    m_waiting  = 1;
                    m_fetching = 0;
                    m_pc       = (m_pc + 1) % W;
                end
            end
            step();
        end
        instr_ready = 1'b0; redirect_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
